// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared ROB id width, opcodes, entry layout and the operand wakeup helper.
package alu_rs_pkg;
  localparam int ROB_W = 4;
  localparam int RS_SIZE_DEF = 8;
  typedef logic [ROB_W-1:0] rob_t;
  localparam logic [6:0] OLUI = 7'b0110111, OAUIPC = 7'b0010111, OJAL = 7'b1101111,
                         OJALR = 7'b1100111, OB = 7'b1100011, ORI = 7'b0010011, ORR = 7'b0110011;
  typedef struct packed {
    logic        h;
    logic [31:0] v;
  } opnd_t;
  typedef struct packed {
    logic [10:0] op;
    opnd_t       o1;
    opnd_t       o2;
    rob_t        q1;
    rob_t        q2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        is_short;
    rob_t        rob_id;
  } entry_t;
  // ALU broadcast has priority when both buses carry the awaited id
  function automatic opnd_t wake(opnd_t o, rob_t q, logic ab, rob_t aid, logic [31:0] av,
                                 logic lb, rob_t lid, logic [31:0] lv);
    return !o.h ? o : (ab && q == aid) ? '{h: 1'b0, v: av} : (lb && q == lid) ? '{h: 1'b0, v: lv} : o;
  endfunction
endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, broadcast and issue signals of the ALU reservation station.
interface alu_rs_if;
  import alu_rs_pkg::*;
  logic        dispatch;
  logic [10:0] d_op;
  logic [31:0] d_v1, d_v2, d_pc, d_imm;
  logic        d_has_q1, d_has_q2, d_is_short;
  rob_t        d_q1, d_q2, d_rob_id;
  logic        alu_bc, lsb_bc;
  rob_t        alu_bc_id, lsb_bc_id;
  logic [31:0] alu_bc_val, lsb_bc_val;
  logic        full, yes, is_short;
  logic [10:0] op;
  logic [31:0] v1, v2, pc, imm;
  rob_t        rob_id;
  modport master(output dispatch, d_op, d_v1, d_v2, d_pc, d_imm, d_has_q1, d_has_q2, d_is_short,
                 d_q1, d_q2, d_rob_id, alu_bc, lsb_bc, alu_bc_id, lsb_bc_id, alu_bc_val, lsb_bc_val,
                 input full, yes, is_short, op, v1, v2, pc, imm, rob_id);
  modport slave(input dispatch, d_op, d_v1, d_v2, d_pc, d_imm, d_has_q1, d_has_q2, d_is_short,
                d_q1, d_q2, d_rob_id, alu_bc, lsb_bc, alu_bc_id, lsb_bc_id, alu_bc_val, lsb_bc_val,
                output full, yes, is_short, op, v1, v2, pc, imm, rob_id);
endinterface

// File: rtl/alu_rs_select.sv
// rs_select: lowest-index priority encoder returning a found flag and the index.
module rs_select #(
  parameter int N = 8,
  parameter int IDX = 3
) (
  input  logic [N-1:0]   req,
  output logic           found,
  output logic [IDX-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? IDX'(i) : idx;
    found = |req;
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; holds uops until operands resolve, issues one per cycle.
// Define RS_WAKEUP_BYPASS_EN to let an entry woken by this cycle's broadcast issue at the same edge.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int RS_IDX = 3
) (
  input logic   clk_in,
  input logic   rst_in,
  input logic   rdy_in,
  input logic   flush,
  alu_rs_if.slave bus
);
  entry_t ent [RS_SIZE];
  opnd_t w1 [RS_SIZE];
  opnd_t w2 [RS_SIZE];
  opnd_t d1, d2;
  logic [RS_SIZE-1:0] busy, rdy_vec;
  logic free_ok, iss_ok;
  logic [RS_IDX-1:0] free_idx, iss_idx;
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w1[i] = wake(ent[i].o1, ent[i].q1, bus.alu_bc, bus.alu_bc_id, bus.alu_bc_val,
                   bus.lsb_bc, bus.lsb_bc_id, bus.lsb_bc_val);
      w2[i] = wake(ent[i].o2, ent[i].q2, bus.alu_bc, bus.alu_bc_id, bus.alu_bc_val,
                   bus.lsb_bc, bus.lsb_bc_id, bus.lsb_bc_val);
`ifdef RS_WAKEUP_BYPASS_EN
      rdy_vec[i] = busy[i] && !w1[i].h && !w2[i].h;
`else
      rdy_vec[i] = busy[i] && !ent[i].o1.h && !ent[i].o2.h;
`endif
    end
    d1 = wake('{h: bus.d_has_q1, v: bus.d_v1}, bus.d_q1, bus.alu_bc, bus.alu_bc_id, bus.alu_bc_val,
              bus.lsb_bc, bus.lsb_bc_id, bus.lsb_bc_val);
    d2 = wake('{h: bus.d_has_q2, v: bus.d_v2}, bus.d_q2, bus.alu_bc, bus.alu_bc_id, bus.alu_bc_val,
              bus.lsb_bc, bus.lsb_bc_id, bus.lsb_bc_val);
  end
  assign bus.full = &busy;
  rs_select #(.N(RS_SIZE), .IDX(RS_IDX)) u_free (.req(~busy), .found(free_ok), .idx(free_idx));
  rs_select #(.N(RS_SIZE), .IDX(RS_IDX)) u_issue (.req(rdy_vec), .found(iss_ok), .idx(iss_idx));
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      bus.yes <= 1'b0;
      bus.op <= '0;
      bus.v1 <= '0;
      bus.v2 <= '0;
      bus.pc <= '0;
      bus.imm <= '0;
      bus.is_short <= 1'b0;
      bus.rob_id <= '0;
    end else if (!rdy_in) begin
      bus.yes <= 1'b0;
    end else if (flush) begin
      busy <= '0;
      bus.yes <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          ent[i].o1 <= w1[i];
          ent[i].o2 <= w2[i];
        end
      end
      bus.yes <= iss_ok;
      if (iss_ok) begin
        busy[iss_idx] <= 1'b0;
        bus.op <= ent[iss_idx].op;
        bus.v1 <= w1[iss_idx].v;
        bus.v2 <= w2[iss_idx].v;
        bus.pc <= ent[iss_idx].pc;
        bus.imm <= ent[iss_idx].imm;
        bus.is_short <= ent[iss_idx].is_short;
        bus.rob_id <= ent[iss_idx].rob_id;
      end
      // a slot freed by this edge's issue is not visible to this edge's dispatch
      if (bus.dispatch && free_ok) begin
        busy[free_idx] <= 1'b1;
        ent[free_idx] <= '{op: bus.d_op, o1: d1, o2: d2, q1: bus.d_q1, q2: bus.d_q2, pc: bus.d_pc,
                           imm: bus.d_imm, is_short: bus.d_is_short, rob_id: bus.d_rob_id};
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed plus random stimulus checked against a slot-level reference model.
module tb_alu_rs;
  import alu_rs_pkg::*;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk_in = 1'b0, rst_in, rdy_in, flush;
  int n_chk = 0, n_fail = 0;
  alu_rs_if bus ();
  alu_rs #(.RS_SIZE(8), .RS_IDX(3)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .bus(bus));
  always #5 clk_in = ~clk_in;
  logic        m_busy[8], m_h1[8], m_h2[8], m_sh[8];
  logic [10:0] m_op[8];
  logic [31:0] m_v1[8], m_v2[8], m_pc[8], m_imm[8];
  logic [3:0]  m_q1[8], m_q2[8], m_rob[8];
  logic        e_yes, e_sh;
  logic [10:0] e_op;
  logic [31:0] e_v1, e_v2, e_pc, e_imm;
  logic [3:0]  e_rob;
  function automatic logic [32:0] wk(logic h, logic [3:0] q, logic [31:0] v);
    if (h && bus.alu_bc && q == bus.alu_bc_id) return {1'b0, bus.alu_bc_val};
    if (h && bus.lsb_bc && q == bus.lsb_bc_id) return {1'b0, bus.lsb_bc_val};
    return {h, v};
  endfunction
  task automatic model();
    logic [32:0] a[8], b[8], da, db;
    int sel, fr;
    bit fl;
    sel = -1; fr = -1; fl = 1'b1;
    if (rst_in) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      {e_yes, e_sh, e_op, e_v1, e_v2, e_pc, e_imm, e_rob} = '0;
    end else if (!rdy_in) begin
      e_yes = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      e_yes = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        a[i] = wk(m_h1[i], m_q1[i], m_v1[i]);
        b[i] = wk(m_h2[i], m_q2[i], m_v2[i]);
        fl &= m_busy[i];
        if (!m_busy[i] && fr < 0) fr = i;
      end
      for (int i = 0; i < 8; i++)
        if (sel < 0 && m_busy[i] && !(BYP ? a[i][32] : m_h1[i]) && !(BYP ? b[i][32] : m_h2[i])) sel = i;
      for (int i = 0; i < 8; i++)
        if (m_busy[i]) begin
          {m_h1[i], m_v1[i]} = a[i];
          {m_h2[i], m_v2[i]} = b[i];
        end
      e_yes = sel >= 0;
      if (sel >= 0) begin
        e_op = m_op[sel]; e_v1 = m_v1[sel]; e_v2 = m_v2[sel]; e_pc = m_pc[sel];
        e_imm = m_imm[sel]; e_sh = m_sh[sel]; e_rob = m_rob[sel];
        m_busy[sel] = 1'b0;
      end
      if (bus.dispatch && !fl) begin
        da = wk(bus.d_has_q1, bus.d_q1, bus.d_v1);
        db = wk(bus.d_has_q2, bus.d_q2, bus.d_v2);
        m_busy[fr] = 1'b1; m_op[fr] = bus.d_op; {m_h1[fr], m_v1[fr]} = da; {m_h2[fr], m_v2[fr]} = db;
        m_q1[fr] = bus.d_q1; m_q2[fr] = bus.d_q2; m_pc[fr] = bus.d_pc; m_imm[fr] = bus.d_imm;
        m_sh[fr] = bus.d_is_short; m_rob[fr] = bus.d_rob_id;
      end
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < 8; i++) f &= m_busy[i];
    return f;
  endfunction
  task automatic step();
    model();
    @(posedge clk_in);
    #1;
    chk("yes", 32'(bus.yes), 32'(e_yes));
    chk("full", 32'(bus.full), 32'(m_full()));
    chk("op", 32'(bus.op), 32'(e_op));
    chk("v1", bus.v1, e_v1);
    chk("v2", bus.v2, e_v2);
    chk("pc", bus.pc, e_pc);
    chk("imm", bus.imm, e_imm);
    chk("is_short", 32'(bus.is_short), 32'(e_sh));
    chk("rob_id", 32'(bus.rob_id), 32'(e_rob));
  endtask
  task automatic idle();
    bus.dispatch = 1'b0; bus.alu_bc = 1'b0; bus.lsb_bc = 1'b0;
  endtask
  task automatic disp(logic [10:0] op, logic [31:0] v1, logic h1, logic [3:0] q1, logic [31:0] v2,
                      logic h2, logic [3:0] q2, logic [31:0] imm, logic [3:0] rob);
    bus.dispatch = 1'b1; bus.d_op = op; bus.d_v1 = v1; bus.d_has_q1 = h1; bus.d_q1 = q1;
    bus.d_v2 = v2; bus.d_has_q2 = h2; bus.d_q2 = q2; bus.d_imm = imm; bus.d_rob_id = rob;
    bus.d_pc = 32'h1000 + 32'(rob) * 4; bus.d_is_short = rob[0];
  endtask
  task automatic bc(bit alu, logic [3:0] id, logic [31:0] val);
    if (alu) begin bus.alu_bc = 1'b1; bus.alu_bc_id = id; bus.alu_bc_val = val; end
    else begin bus.lsb_bc = 1'b1; bus.lsb_bc_id = id; bus.lsb_bc_val = val; end
  endtask
  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    idle();
    {bus.d_op, bus.d_v1, bus.d_v2, bus.d_pc, bus.d_imm} = '0;
    {bus.d_has_q1, bus.d_has_q2, bus.d_is_short, bus.d_q1, bus.d_q2, bus.d_rob_id} = '0;
    {bus.alu_bc_id, bus.alu_bc_val, bus.lsb_bc_id, bus.lsb_bc_val} = '0;
    #2;
    step();
    chk("reset_full", 32'(bus.full), 0);
    rst_in = 1'b0;
    disp({4'b0, ORI}, 5, 0, 0, 0, 0, 0, 3, 2);
    step();
    idle();
    step();
    chk("addi_yes", 32'(bus.yes), 1);
    chk("addi_v1", bus.v1, 5);
    chk("addi_imm", bus.imm, 3);
    chk("addi_rob", 32'(bus.rob_id), 2);
    step();
    chk("addi_done", 32'(bus.yes), 0);
    disp({4'b0, ORR}, 0, 1, 4, 7, 0, 0, 0, 3);
    step();
    idle();
    step();
    bc(1, 4, 10);
    step();
    idle();
    repeat (2) step();
    disp({4'b0, ORR}, 0, 1, 6, 1, 0, 0, 0, 5);
    bc(0, 6, 32'h55);
    step();
    idle();
    step();
    chk("lsb_wake_v1", bus.v1, 32'h55);
    disp({4'b0, ORR}, 0, 1, 6, 2, 0, 0, 0, 7);
    bc(1, 6, 32'haa);
    bc(0, 6, 32'h55);
    step();
    idle();
    step();
    chk("alu_prio_v1", bus.v1, 32'haa);
    for (int i = 0; i < 9; i++) begin
      disp({4'b0, ORR}, 0, 1, 1, 32'(i), 0, 0, 0, 4'(i + 8));
      step();
    end
    chk("fill_full", 32'(bus.full), 1);
    idle();
    bc(1, 1, 32'h11);
    step();
    idle();
    repeat (9) step();
    for (int i = 0; i < 4; i++) begin
      disp({4'b0, OB}, 0, 1, 9, 0, 0, 0, 0, 4'(i));
      step();
    end
    flush = 1'b1;
    disp({4'b0, ORI}, 1, 0, 0, 0, 0, 0, 0, 4'd12);
    step();
    chk("flush_yes", 32'(bus.yes), 0);
    flush = 1'b0;
    idle();
    bc(1, 9, 32'h99);
    step();
    idle();
    repeat (2) step();
    disp({4'b0, OJAL}, 0, 0, 0, 0, 0, 0, 32'h20, 4'd13);
    step();
    idle();
    rdy_in = 1'b0;
    repeat (3) step();
    rdy_in = 1'b1;
    step();
    chk("unfreeze_yes", 32'(bus.yes), 1);
    step();
    for (int i = 0; i < 3; i++) begin
      disp({4'b0, OLUI}, 32'(i), 0, 0, 0, 0, 0, 0, 4'(i + 1));
      step();
    end
    idle();
    rst_in = 1'b1;
    step();
    chk("rst_yes", 32'(bus.yes), 0);
    chk("rst_full", 32'(bus.full), 0);
    rst_in = 1'b0;
    repeat (3) step();
    for (int c = 0; c < 400; c++) begin
      rdy_in = ($urandom % 10) != 0;
      flush = ($urandom % 50) == 0;
      bus.dispatch = 1'($urandom);
      bus.d_op = 11'($urandom); bus.d_v1 = $urandom; bus.d_v2 = $urandom;
      bus.d_has_q1 = 1'($urandom); bus.d_has_q2 = ($urandom % 4) == 0;
      bus.d_q1 = 4'($urandom % 8); bus.d_q2 = 4'($urandom % 8);
      bus.d_pc = $urandom; bus.d_imm = $urandom; bus.d_is_short = 1'($urandom); bus.d_rob_id = 4'($urandom);
      bus.alu_bc = ($urandom % 3) == 0; bus.alu_bc_id = 4'($urandom % 8); bus.alu_bc_val = $urandom;
      bus.lsb_bc = ($urandom % 3) == 0; bus.lsb_bc_id = 4'($urandom % 8); bus.lsb_bc_val = $urandom;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that buffers dispatched integer/branch/jump µops until both source operands are known, then issues one µop per cycle to the ALU.
- Sits between the decoder/dispatch stage and the ALU.
- Snoops two result broadcast buses, the ALU result and the load/store result, to resolve pending operand tags by ROB id.

Parameters:
RS_SIZE, 8, number of entries (power of two, 2..16)
RS_IDX, 3, log2(RS_SIZE), index width

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low = freeze
flush  input  1  misprediction clear, synchronous
dispatch  input  1  write new µop this cycle
d_op  input  11  opcode[6:0], funct3[9:7], funct7 bit[10]
d_v1, d_v2  input  32  operand values (valid when matching has_q is 0)
d_has_q1, d_has_q2  input  1  operand pending
d_q1, d_q2  input  `ROB_R  producing ROB id
d_pc, d_imm  input  32  pc, immediate
d_is_short  input  1  compressed instruction
d_rob_id  input  `ROB_R  destination ROB id
alu_bc  input  1  ALU broadcast valid
alu_bc_id  input  `ROB_R  ALU broadcast ROB id
alu_bc_val  input  32  ALU broadcast value
lsb_bc  input  1  load/store broadcast valid
lsb_bc_id  input  `ROB_R  load/store broadcast ROB id
lsb_bc_val  input  32  load/store broadcast value
full  output  1  no free entry (combinational from current state)
yes  output  1  issue valid to ALU (registered)
op  output  11  issued opcode (registered)
v1, v2  output  32  issued operand values (registered)
pc, imm  output  32  issued pc, immediate (registered)
is_short  output  1  issued compressed flag (registered)
rob_id  output  `ROB_R  issued destination ROB id (registered)

Behaviour:
- Reset (rst_in=1 at posedge):
  - All entries not busy.
  - yes=0; op, v1, v2, pc, imm, is_short, rob_id = 0.
  - full=0.
  - Reset overrides flush, rdy_in and dispatch.
- Per-entry state: busy, op, v1, v2, has_q1, has_q2, q1, q2, pc, imm, is_short, rob_id.
- Dispatch:
  - Applies when dispatch=1, full=0 and rdy_in=1.
  - Writes the lowest-index free entry.
  - dispatch while full is ignored; the dispatcher must gate on full.
  - Dispatch-time wakeup: if d_has_qN=1 and a broadcast valid this cycle matches d_qN, the entry stores the broadcast value with has_qN=0.
  - If both broadcasts match, alu_bc wins.
- Wakeup:
  - Every cycle, each busy entry with has_qN=1 and qN equal to a valid broadcast id captures that value and clears has_qN.
- Select and issue:
  - Ready = busy && !has_q1 && !has_q2, on registered state.
  - The lowest-index ready entry issues.
  - At the posedge the output registers load that entry, yes<=1, and the entry's busy clears.
  - No ready entry: yes<=0.
  - Minimum latency: dispatch with operands ready at edge N gives yes=1 after edge N+1.
  - A freed slot is reusable by a dispatch at the following edge, not the same edge, because full reflects pre-edge state.
- Simultaneous events:
  - Issue and dispatch in the same cycle are both allowed when full=0.
  - Wakeup and issue of other entries proceed in the same cycle.
- flush=1 (with rdy_in=1):
  - All busy bits clear and yes<=0 at that edge.
  - The dispatch in the same cycle is dropped.
- rdy_in=0:
  - Entries frozen: no dispatch, wakeup or issue.
  - yes<=0 so the ALU does not re-execute.
  - Broadcasts arriving while rdy_in=0 are lost; the producers also stall on rdy_in, so none arrive.
- full = AND of all busy bits.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined:
  - An entry whose only pending operands match valid broadcasts this cycle counts as ready.
  - It may issue at that edge, with the broadcast value muxed into v1/v2.
  - Saves one cycle on dependent chains.
- Undefined:
  - The woken entry becomes ready only next cycle.
  - Issue selection uses registered state only.

Decomposition:
- const.v (shared): `ROB_R, opcode defines (`olui, `oauipc, `ojal, `ojalr, `ob, `ori, `orr), plus RS_SIZE default.
- Sub-module rs_select:
  - Parameterised lowest-index priority encoder over RS_SIZE bits.
  - Outputs found flag and index.
  - Instantiated twice: once for the free slot (~busy), once for the ready vector.

Test Plan:
- Reset, then dispatch addi (op ori/000, d_v1=5, d_imm=3, no q, rob 2) -> two edges later yes=1, v1=5, imm=3, rob_id=2, then yes=0.
- Dispatch add with d_has_q1=1, q1=4, d_v2=7 -> no issue; alu_bc id4 val10 -> next edge entry ready, issue v1=10, v2=7 (one edge earlier with RS_WAKEUP_BYPASS_EN).
- Dispatch with q1=6 in the same cycle as lsb_bc id6 val0x55 -> issues v1=0x55; alu_bc and lsb_bc both id6 with different values -> alu value used.
- Fill 8 entries all pending on q=1 -> full=1; 9th dispatch ignored; alu_bc id1 -> entries issue one per cycle in index order 0..7, full drops after first issue.
- 4 entries busy, flush with simultaneous dispatch -> all cleared, yes=0, no later issue; rdy_in=0 for 3 cycles with ready entry -> yes=0 throughout, issues once after rdy_in=1.
- rst_in asserted mid-occupancy with yes=1 -> next edge yes=0, full=0, prior entries never issue.
